gcd_top: RTL and testbench
==========================

// Module: gcd_top
// PURPOSE
//   Iterative subtract-and-compare GCD engine: FSM control plus datapath.
//   A single-cycle start pulse captures unsigned operands A and B.
//   The result is written to res and held until the next completed computation.
//   Stand-alone arithmetic block; one clock domain, no bus interface.
// PARAMETERS
//   N  32  operand/result width in bits (unsigned)
// PORTS
//   clk    in   1  rising-edge clock
//   n_rst  in   1  reset: one clock; asynchronous, active-low
//   start  in   1  operand-capture request, sampled at rising clk edge
//   A      in   N  operand 1, sampled only when start accepted
//   B      in   N  operand 2, sampled only when start accepted
//   res    out  N  registered GCD result, held between computations
//   done   out  1  one-cycle pulse, high in the cycle res takes a new value
// BEHAVIOUR
//   - Reset: state=IDLE, x=y=0, res=0, done=0; async assert, synchronous release.
//   - Internal registers: x,y (N bits each).
//   - States: IDLE, CALC, DONE.
//   - IDLE:
//     - start=1: x<=A, y<=B, go CALC.
//     - start=0: hold.
//   - CALC, evaluated once per clock edge:
//     - x==0 or y==0: res<=x|y (gcd(a,0)=a; gcd(0,0)=0), go DONE.
//     - x==y: res<=x, go DONE.
//     - x>y: x<=x-y.
//     - x<y: y<=y-x.
//   - DONE: done=1 for this single cycle, then go IDLE; res unchanged.
//   - Latency:
//     - k = number of subtraction steps.
//     - res valid k+2 rising edges after the start-capture edge.
//     - Examples: 24,8 -> k=2 -> 4 edges; 36,60 -> k=3 -> 5 edges.
//     - Worst case, 2^N-1 and 1: ~2^N edges. The caller must wait for done.
//   - Subtraction never underflows: only the larger operand is reduced, and
//     both operands stay nonzero inside the loop.
//   - res changes only on CALC termination.
//   - Reset mid-operation: computation abandoned, res=0.
//   - start while in CALC/DONE: ignored by default (see CONFIGURATION).
//   - A/B may change freely after capture; they do not affect the running computation.
//   - Combinational next-state and datapath logic; all outputs registered.
// CONFIGURATION
//   GCD_RESTART_EN
//     - defined: start=1 in CALC or DONE reloads x<=A, y<=B and enters CALC.
//       Abort-and-restart; res keeps its old value; no done pulse for the aborted job.
//     - undefined: start is ignored outside IDLE; the running job completes.
// TESTING
//   - reset asserted, then released -> res=0, done=0, state IDLE.
//   - A=24,B=8, 1-cycle start -> done pulse, res=8 within 20 cycles.
//   - A=36,B=60 -> res=12 (x<y branch).
//   - A=50,B=10 -> res=10.
//   - A=0,B=7 -> res=7.
//   - A=0,B=0 -> res=0.
//   - A=17,B=5 -> res=1 (coprime).
//   - Mid-operation abort: A=1000,B=1, start, assert n_rst after 10 cycles ->
//     res=0 immediately, FSM in IDLE.
//   - Restart: A=1000,B=1, start; after 5 cycles start with A=9,B=6.
//     - GCD_RESTART_EN defined: res=3.
//     - undefined: res=1 after job 1 ends; the second start is dropped.

Source files
------------

// File: rtl/gcd_top.sv
// Iterative subtract-and-compare GCD engine with registered result and done pulse.
// Optional GCD_RESTART_EN: a start outside IDLE aborts the running job and reloads operands.
module gcd_top #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic [N-1:0] res,
   output logic         done
);

   // state | meaning
   // IDLE  | waiting for start, res holds last result
   // CALC  | one subtract/compare step per clock
   // DONE  | done pulse cycle, returns to IDLE
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

`ifdef GCD_RESTART_EN
   localparam logic RESTART_EN = 1'b1;
`else
   localparam logic RESTART_EN = 1'b0;
`endif

   state_t       state_q, state_d;
   logic [N-1:0] x_q, x_d;
   logic [N-1:0] y_q, y_d;
   logic [N-1:0] res_q, res_d;
   logic         done_q, done_d;
   logic [1:0]   rst_sync_q;
   logic         rst_core_n;

   // Reset asserts immediately but releases on a clock edge.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_core_n = rst_sync_q[1];

   always_ff @(posedge clk or negedge rst_core_n) begin
      if (!rst_core_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         res_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         res_q   <= res_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      res_d   = res_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               x_d     = A;
               y_d     = B;
               state_d = CALC;
            end
         end
         CALC: begin
            if ((x_q == '0) || (y_q == '0)) begin
               res_d   = x_q | y_q;
               done_d  = 1'b1;
               state_d = DONE;
            end else if (x_q == y_q) begin
               res_d   = x_q;
               done_d  = 1'b1;
               state_d = DONE;
            end else if (x_q > y_q) begin
               x_d = x_q - y_q;
            end else begin
               y_d = y_q - x_q;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Abort-and-restart discards any termination reached on this same edge.
      if (RESTART_EN && start && (state_q != IDLE)) begin
         x_d     = A;
         y_d     = B;
         res_d   = res_q;
         done_d  = 1'b0;
         state_d = CALC;
      end
   end

   assign res  = res_q;
   assign done = done_q;

endmodule

// File: tb/tb_gcd_top.sv
// Scoreboard bench for gcd_top: expected GCDs are queued at start and checked on done.
module tb_gcd_top;

   localparam int N = 32;

   logic         clk;
   logic         n_rst;
   logic         start;
   logic [N-1:0] a_in;
   logic [N-1:0] b_in;
   logic [N-1:0] res;
   logic         done;

   int checks   = 0;
   int failures = 0;
   logic [N-1:0] exp_q[$];

   gcd_top #(.N(N)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .start (start),
      .A     (a_in),
      .B     (b_in),
      .res   (res),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [N-1:0] gcd_ref(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [N-1:0] p, q, t;
      p = a;
      q = b;
      while (q != '0) begin
         t = p % q;
         p = q;
         q = t;
      end
      return p;
   endfunction

   // Starts a job, waits for done within budget, checks result and pulse width.
   task automatic run_job(input logic [N-1:0] a, input logic [N-1:0] b, input int budget,
                          input string name);
      int n;
      logic [N-1:0] exp_v;
      @(negedge clk);
      a_in  = a;
      b_in  = b;
      start = 1'b1;
      exp_q.push_back(gcd_ref(a, b));
      @(negedge clk);
      start = 1'b0;
      a_in  = $urandom;
      b_in  = $urandom;
      n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL %s timeout: done not seen in %0d cycles", name, budget);
         void'(exp_q.pop_front());
         return;
      end
      exp_v = exp_q.pop_front();
      checks++;
      if (res !== exp_v) begin
         failures++;
         $display("FAIL %s res: got %0d expected %0d", name, res, exp_v);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || res !== exp_v) begin
         failures++;
         $display("FAIL %s hold: done=%0b res=%0d expected done=0 res=%0d", name, done, res, exp_v);
      end
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (res !== '0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_asserted: res=%0d done=%0b expected res=0 done=0", res, done);
      end
      n_rst = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (res !== '0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_released: res=%0d done=%0b expected res=0 done=0", res, done);
      end
   endtask

   task automatic test_basic();
      logic [N-1:0] ta[6];
      logic [N-1:0] tb[6];
      ta = '{24, 36, 50, 0, 0, 17};
      tb = '{ 8, 60, 10, 7, 0,  5};
      for (int i = 0; i < 6; i++) run_job(ta[i], tb[i], 20, $sformatf("basic_%0d_%0d", ta[i], tb[i]));
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] a, b;
      for (int i = 0; i < 8; i++) begin
         a = (i == 3) ? '0 : N'($urandom_range(1, 200));
         b = (i == 5) ? '0 : N'($urandom_range(1, 200));
         run_job(a, b, 450, $sformatf("b2b_%0d", i));
      end
      // Swapped, both-equal and one-equals-one boundaries.
      run_job(8, 24, 20, "swap_8_24");
      run_job(42, 42, 20, "equal_42");
      run_job(1, 9, 20, "one_9");
   endtask

   task automatic test_abort();
      int seen;
      run_job(21, 14, 20, "pre_abort");
      @(negedge clk);
      a_in  = 1000;
      b_in  = 1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      n_rst = 1'b0;
      #1;
      checks++;
      if (res !== '0 || done !== 1'b0) begin
         failures++;
         $display("FAIL abort_immediate: res=%0d done=%0b expected res=0 done=0", res, done);
      end
      @(negedge clk);
      n_rst = 1'b1;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) seen++;
      end
      checks++;
      if (seen != 0 || res !== '0) begin
         failures++;
         $display("FAIL abort_idle: done_pulses=%0d res=%0d expected 0 and 0", seen, res);
      end
      run_job(36, 60, 20, "post_abort");
   endtask

   task automatic test_restart();
      int n, extra;
      logic [N-1:0] exp_v;
      @(negedge clk);
      a_in  = 1000;
      b_in  = 1;
      start = 1'b1;
`ifndef GCD_RESTART_EN
      exp_q.push_back(gcd_ref(1000, 1));
`endif
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      a_in  = 9;
      b_in  = 6;
      start = 1'b1;
`ifdef GCD_RESTART_EN
      exp_q.push_back(gcd_ref(9, 6));
`endif
      @(negedge clk);
      start = 1'b0;
      a_in  = 77;
      b_in  = 33;
      n = 0;
      while (!done && n < 1200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL restart timeout: done not seen in 1200 cycles");
         void'(exp_q.pop_front());
         return;
      end
      exp_v = exp_q.pop_front();
      checks++;
      if (res !== exp_v) begin
         failures++;
         $display("FAIL restart res: got %0d expected %0d", res, exp_v);
      end
      extra = 0;
      repeat (30) begin
         @(negedge clk);
         if (done) extra++;
      end
      checks++;
      if (extra != 0 || res !== exp_v) begin
         failures++;
         $display("FAIL restart_single_done: extra_pulses=%0d res=%0d expected 0 and %0d",
                  extra, res, exp_v);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_abort();
      test_restart();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
